// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch and load/store ports.
// Define STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive fetch losses.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t     state;
    logic       owner_dm;
    logic       owner_we;
    logic [1:0] lat_cnt;
    logic       arb;
    logic       force_if;
    logic       if_win;
    logic       dm_win;
    logic       resp;
`ifdef STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    assign force_if = starve_cnt >= 4'(STARVE_LIMIT);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            starve_cnt <= '0;
        else if (if_win)
            starve_cnt <= '0;
        else if (arb && if_req_i)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign force_if = 1'b0;
`endif
    // Gating with rst_n_i keeps the combinational grant path quiet while reset is held.
    assign arb         = rst_n_i && (state == IDLE || state == RESP);
    assign if_win      = arb && if_req_i && (force_if || !dm_req_i);
    assign dm_win      = arb && dm_req_i && !if_win;
    assign if_gnt_o    = if_win;
    assign dm_gnt_o    = dm_win;
    assign mem_en_o    = if_win || dm_win;
    assign mem_we_o    = dm_win && dm_we_i;
    assign mem_addr_o  = dm_win ? dm_addr_i : (if_win ? if_addr_i : '0);
    assign mem_wdata_o = mem_we_o ? dm_wdata_i : '0;
    assign resp        = rst_n_i && state == RESP;
    assign if_rvalid_o = resp && !owner_dm;
    assign dm_rvalid_o = resp && owner_dm;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = (dm_rvalid_o && !owner_we) ? mem_rdata_i : '0;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            owner_dm <= 1'b0;
            owner_we <= 1'b0;
            lat_cnt  <= '0;
        end else if (mem_en_o) begin
            owner_dm <= dm_win;
            owner_we <= mem_we_o;
            lat_cnt  <= 2'(MEM_LAT - 1);
            state    <= (MEM_LAT == 1) ? RESP : WAIT;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 2'd1;
            state   <= (lat_cnt == 2'd1) ? RESP : WAIT;
        end else begin
            state <= IDLE;
        end
    end
endmodule
